lte_dw_dfe_antswitch_sched: RTL and testbench
=============================================

Name: lte_dw_dfe_antswitch_sched

Overview:
- Per-subframe antenna-position scheduler for the downlink DFE antenna-switch transpose stage.
- Holds a CPU-written shadow table of up to 4 antenna-position patterns plus a bandwidth mode.
- Applies the table atomically on a frame head and steps through patterns once per subframe.
- Drives ant_pos, mod_sel and a re-timed frame strobe into the 245.76 MHz transpose datapath.

Parameters:
- SF_LEN, 245760: clock cycles per 1 ms subframe at 245.76 MHz.
- SF_PER_FRAME, 10: subframes per radio frame.
- ID_PAT, 32'h76543210: identity pattern used at reset and when disabled.

Ports:
- sys_clk_245p76  in  1  system clock.
- sys_rst_245p76  in  1  reset, asynchronous, active-low.
- i_enable  in  1  scheduler enable. Low forces the identity pattern.
- i_fram  in  1  frame head, one-cycle pulse.
- i_cfg_wr  in  1  shadow table write strobe.
- i_cfg_sel  in  2  pattern slot written.
- i_cfg_data  in  32  pattern: 8 nibbles, each bits[2:0]=antenna index, bit3=0.
- i_cfg_num_pat  in  2  patterns in use minus 1. Sampled on commit.
- i_cfg_mod_sel  in  2  0=5M 1=10M 2=15M 3=20M. Sampled on commit.
- i_cfg_commit  in  1  request to apply shadow at next frame head.
- i_err_clr  in  1  clears o_cfg_err.
- o_cfg_busy  out  1  commit pending.
- o_cfg_err  out  1  sticky: rejected write or commit.
- o_fram  out  1  frame strobe aligned to the new o_ant_pos.
- o_ant_pos  out  32  active pattern to datapath.
- o_mod_sel  out  2  active mode.
- o_pat_idx  out  2  current pattern slot.
- o_sf_cnt  out  4  current subframe, 0..9.
- o_wdog  out  1  sticky: internal frame generated.

Behaviour:
- Reset values:
  - o_ant_pos = ID_PAT. o_mod_sel = 3.
  - o_fram, o_pat_idx, o_sf_cnt, o_cfg_busy, o_cfg_err, o_wdog = 0.
  - Active table and shadow table all ID_PAT. Active num_pat = 0.
  - tick_cnt = 0.
- Write validation, on i_cfg_wr:
  - Accept only if every nibble has bit3 = 0 and all 8 indices are distinct, i.e. a permutation of 0..7.
  - Invalid write: shadow slot unchanged, o_cfg_err = 1 the next cycle.
- FSM, 2 states:
  - IDLE: o_cfg_busy = 0. i_cfg_commit latches num_pat and mod_sel into pending registers -> PEND.
  - PEND: o_cfg_busy = 1. On i_fram, copy shadow table and pending values into the active set in the same cycle -> IDLE.
  - i_cfg_commit while in PEND is ignored and sets o_cfg_err.
- Simultaneous events:
  - i_fram and i_cfg_commit in the same cycle (from IDLE): the commit applies at the following frame, not this one.
  - i_cfg_wr and the copy on i_fram in the same cycle: the copy uses pre-write shadow contents.
  - i_err_clr and a new error in the same cycle: the error wins.
- Timing counters:
  - i_fram: tick_cnt = 0, sf_cnt = 0, pat_idx = 0.
  - Otherwise tick_cnt counts 0..SF_LEN-1 and wraps.
  - On wrap: sf_cnt increments, 9 -> 0. pat_idx increments, num_pat -> 0.
  - i_fram in mid-subframe restarts all counters.
  - i_fram coincident with a wrap: i_fram wins.
- Output latency: all outputs registered.
  - o_fram = i_fram delayed 1 cycle.
  - o_ant_pos = active[pat_idx] (after any copy), 1 cycle after the event. o_fram and the new pattern appear on the same cycle.
  - o_mod_sel changes only with o_fram.
- i_enable = 0: o_ant_pos = ID_PAT and o_pat_idx = 0. Counters and FSM keep running. o_fram still passes.
- Reset mid-operation: a pending commit is discarded and shadow contents are lost.

Optional Feature:
- Macro ANTSW_SCHED_WDOG_EN.
- Defined:
  - If no i_fram arrives within SF_PER_FRAME*SF_LEN cycles of the last frame head, the block generates an internal frame head at that count.
  - The internal frame head behaves exactly like i_fram: o_fram pulse, counters reset, pending commit applied.
  - o_wdog is set sticky; cleared by i_err_clr.
- Undefined: no internal frame is generated, counters free-run, and o_wdog is tied to 0.

Test Plan:
- SF_LEN=16. Reset, then i_fram -> o_fram 1 cycle later, o_ant_pos=32'h76543210, o_mod_sel=3, o_sf_cnt increments every 16 cycles, 9 -> 0.
- Write slot0=32'h01234567 and slot1=32'h10325476, commit with num_pat=1, mod_sel=0, then i_fram -> o_cfg_busy low after i_fram, o_ant_pos alternates 01234567/10325476 each subframe, o_mod_sel=0.
- Write 32'h00234567 (duplicate index) -> o_cfg_err=1, slot unchanged; i_err_clr -> 0.
- Write 32'h81234567 (bit3 set) -> o_cfg_err=1, slot unchanged.
- Commit in the same cycle as i_fram -> o_ant_pos unchanged at that frame, updates at the next i_fram. A second commit while busy -> o_cfg_err=1.
- ANTSW_SCHED_WDOG_EN, SF_LEN=16: stop i_fram -> internal o_fram 160 cycles after the last head, o_wdog=1, o_sf_cnt=0.

Source files
------------

// File: rtl/lte_dw_dfe_antswitch_sched.sv
// lte_dw_dfe_antswitch_sched: per-subframe antenna-position scheduler for the DFE antenna-switch transpose stage.
// Define ANTSW_SCHED_WDOG_EN to synthesise an internal frame head when i_fram stops arriving.
module lte_dw_dfe_antswitch_sched #(
  parameter int          SF_LEN       = 245760,
  parameter int          SF_PER_FRAME = 10,
  parameter logic [31:0] ID_PAT       = 32'h76543210
) (
  input  logic        sys_clk_245p76,
  input  logic        sys_rst_245p76,
  input  logic        i_enable,
  input  logic        i_fram,
  input  logic        i_cfg_wr,
  input  logic [1:0]  i_cfg_sel,
  input  logic [31:0] i_cfg_data,
  input  logic [1:0]  i_cfg_num_pat,
  input  logic [1:0]  i_cfg_mod_sel,
  input  logic        i_cfg_commit,
  input  logic        i_err_clr,
  output logic        o_cfg_busy,
  output logic        o_cfg_err,
  output logic        o_fram,
  output logic [31:0] o_ant_pos,
  output logic [1:0]  o_mod_sel,
  output logic [1:0]  o_pat_idx,
  output logic [3:0]  o_sf_cnt,
  output logic        o_wdog
);
  localparam int TW = (SF_LEN > 1) ? $clog2(SF_LEN) : 1;
  typedef enum logic {IDLE, PEND} state_t;
  state_t      state, state_nxt;
  logic [31:0] shadow [4];
  logic [31:0] active [4];
  logic [31:0] active_nxt [4];
  logic [1:0]  act_num, pend_num, pend_mod;
  logic [TW-1:0] tick;
  logic [1:0]  pat, pat_nxt;
  logic [7:0]  seen;
  logic        wrap, last_sf, wd_fire, fram, copy, wr_ok, err_set;
  assign wrap    = tick == TW'(SF_LEN - 1);
  assign last_sf = o_sf_cnt == 4'(SF_PER_FRAME - 1);
  assign fram    = i_fram | wd_fire;
  assign copy    = (state == PEND) & fram;
  assign err_set = (i_cfg_wr & ~wr_ok) | ((state == PEND) & i_cfg_commit);
  // A write is legal only if its 8 nibbles form a permutation of 0..7.
  always_comb begin
    seen  = '0;
    wr_ok = 1'b1;
    for (int n = 0; n < 8; n++) begin
      seen  = seen | (8'd1 << i_cfg_data[4*n +: 3]);
      wr_ok = wr_ok & ~i_cfg_data[4*n+3];
    end
    wr_ok = wr_ok & (&seen);
  end
  always_comb begin
    pat_nxt = fram ? 2'd0 : wrap ? ((pat == act_num) ? 2'd0 : pat + 2'd1) : pat;
    for (int k = 0; k < 4; k++) active_nxt[k] = copy ? shadow[k] : active[k];
  end
  always_ff @(posedge sys_clk_245p76 or negedge sys_rst_245p76) begin
    if (!sys_rst_245p76) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = (state == IDLE) ? (i_cfg_commit ? PEND : IDLE) : (fram ? IDLE : PEND);
  end
  always_comb begin
    o_cfg_busy = state == PEND;
  end
  always_ff @(posedge sys_clk_245p76 or negedge sys_rst_245p76) begin
    if (!sys_rst_245p76) begin
      for (int k = 0; k < 4; k++) begin
        shadow[k] <= ID_PAT;
        active[k] <= ID_PAT;
      end
      act_num   <= '0;
      pend_num  <= '0;
      pend_mod  <= 2'd3;
      o_mod_sel <= 2'd3;
    end else begin
      if (i_cfg_wr && wr_ok) shadow[i_cfg_sel] <= i_cfg_data;
      if (copy) begin
        active    <= shadow;
        act_num   <= pend_num;
        o_mod_sel <= pend_mod;
      end
      if (state == IDLE && i_cfg_commit) begin
        pend_num <= i_cfg_num_pat;
        pend_mod <= i_cfg_mod_sel;
      end
    end
  end
  // Counters restart on any frame head; outputs are registered from next-state values so they align with o_fram.
  always_ff @(posedge sys_clk_245p76 or negedge sys_rst_245p76) begin
    if (!sys_rst_245p76) begin
      tick      <= '0;
      o_sf_cnt  <= '0;
      pat       <= '0;
      o_fram    <= 1'b0;
      o_ant_pos <= ID_PAT;
      o_pat_idx <= '0;
      o_cfg_err <= 1'b0;
    end else begin
      tick      <= (fram | wrap) ? '0 : tick + 1'b1;
      o_sf_cnt  <= fram ? 4'd0 : wrap ? (last_sf ? 4'd0 : o_sf_cnt + 4'd1) : o_sf_cnt;
      pat       <= pat_nxt;
      o_fram    <= fram;
      o_ant_pos <= i_enable ? active_nxt[pat_nxt] : ID_PAT;
      o_pat_idx <= i_enable ? pat_nxt : 2'd0;
      o_cfg_err <= err_set | (o_cfg_err & ~i_err_clr);
    end
  end
`ifdef ANTSW_SCHED_WDOG_EN
  assign wd_fire = wrap & last_sf & ~i_fram;
  always_ff @(posedge sys_clk_245p76 or negedge sys_rst_245p76) begin
    if (!sys_rst_245p76) o_wdog <= 1'b0;
    else o_wdog <= wd_fire | (o_wdog & ~i_err_clr);
  end
`else
  assign wd_fire = 1'b0;
  assign o_wdog  = 1'b0;
`endif
endmodule

// File: tb/tb_lte_dw_dfe_antswitch_sched.sv
// tb_lte_dw_dfe_antswitch_sched: directed stimulus with a cycle-level reference model and literal spot checks.
module tb_lte_dw_dfe_antswitch_sched;
  localparam int SF = 16;
  localparam int FR = 10;
  localparam logic [31:0] ID = 32'h76543210;
`ifdef ANTSW_SCHED_WDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n;
  logic i_enable, i_fram, i_cfg_wr, i_cfg_commit, i_err_clr;
  logic [1:0] i_cfg_sel, i_cfg_num_pat, i_cfg_mod_sel;
  logic [31:0] i_cfg_data;
  logic o_cfg_busy, o_cfg_err, o_fram, o_wdog;
  logic [31:0] o_ant_pos;
  logic [1:0] o_mod_sel, o_pat_idx;
  logic [3:0] o_sf_cnt;
  int checks = 0;
  int errors = 0;

  lte_dw_dfe_antswitch_sched #(.SF_LEN(SF), .SF_PER_FRAME(FR), .ID_PAT(ID)) dut (
    .sys_clk_245p76(clk), .sys_rst_245p76(rst_n), .i_enable(i_enable), .i_fram(i_fram),
    .i_cfg_wr(i_cfg_wr), .i_cfg_sel(i_cfg_sel), .i_cfg_data(i_cfg_data),
    .i_cfg_num_pat(i_cfg_num_pat), .i_cfg_mod_sel(i_cfg_mod_sel), .i_cfg_commit(i_cfg_commit),
    .i_err_clr(i_err_clr), .o_cfg_busy(o_cfg_busy), .o_cfg_err(o_cfg_err), .o_fram(o_fram),
    .o_ant_pos(o_ant_pos), .o_mod_sel(o_mod_sel), .o_pat_idx(o_pat_idx), .o_sf_cnt(o_sf_cnt),
    .o_wdog(o_wdog));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_perm(input logic [31:0] d);
    for (int a = 0; a < 8; a++) begin
      if (d[4*a+3]) return 1'b0;
      for (int b = a + 1; b < 8; b++) if (d[4*a +: 3] == d[4*b +: 3]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Reference model: frame position is cycles since the last head; table state follows the commit rules.
  logic [31:0] m_shadow [4];
  logic [31:0] m_active [4];
  int m_num, m_mod, m_pnum, m_pmod, m_since;
  bit m_pend, m_err, m_wdog, m_fram, m_en, m_valid = 1'b0, m_head, m_ok;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        m_shadow[k] = ID;
        m_active[k] = ID;
      end
      m_num = 0; m_mod = 3; m_pnum = 0; m_pmod = 3; m_since = 0;
      m_pend = 0; m_err = 0; m_wdog = 0; m_fram = 0; m_en = 1; m_valid = 1;
    end else begin
      m_head = i_fram || (WD && m_since == SF * FR - 1);
      m_ok = is_perm(i_cfg_data);
      m_err = ((i_cfg_wr && !m_ok) || (i_cfg_commit && m_pend)) ? 1'b1 : (i_err_clr ? 1'b0 : m_err);
      if (m_head && !i_fram) m_wdog = 1'b1;
      else if (i_err_clr) m_wdog = 1'b0;
      if (m_pend) begin
        if (m_head) begin
          m_active = m_shadow;
          m_num = m_pnum;
          m_mod = m_pmod;
          m_pend = 0;
        end
      end else if (i_cfg_commit) begin
        m_pend = 1;
        m_pnum = i_cfg_num_pat;
        m_pmod = i_cfg_mod_sel;
      end
      if (i_cfg_wr && m_ok) m_shadow[i_cfg_sel] = i_cfg_data;
      m_since = m_head ? 0 : m_since + 1;
      m_fram = m_head;
      m_en = i_enable;
    end
  end

  int c_sf, c_pat;
  always @(negedge clk) begin
    if (m_valid) begin
      c_sf = (m_since / SF) % FR;
      c_pat = m_en ? (m_since / SF) % (m_num + 1) : 0;
      chk("fram", o_fram, m_fram);
      chk("ant_pos", o_ant_pos, m_en ? m_active[c_pat] : ID);
      chk("mod_sel", o_mod_sel, m_mod);
      chk("pat_idx", o_pat_idx, c_pat);
      chk("sf_cnt", o_sf_cnt, c_sf);
      chk("busy", o_cfg_busy, m_pend);
      chk("err", o_cfg_err, m_err);
      chk("wdog", o_wdog, m_wdog);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_fram();
    i_fram = 1'b1;
    cyc(1);
    i_fram = 1'b0;
  endtask

  task automatic wr(input logic [1:0] sel, input logic [31:0] data);
    i_cfg_wr = 1'b1; i_cfg_sel = sel; i_cfg_data = data;
    cyc(1);
    i_cfg_wr = 1'b0;
  endtask

  task automatic commit(input logic [1:0] num, input logic [1:0] mods);
    i_cfg_commit = 1'b1; i_cfg_num_pat = num; i_cfg_mod_sel = mods;
    cyc(1);
    i_cfg_commit = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got still running expected finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; i_enable = 1'b1; i_fram = 1'b0; i_cfg_wr = 1'b0; i_cfg_commit = 1'b0;
    i_err_clr = 1'b0; i_cfg_sel = '0; i_cfg_num_pat = '0; i_cfg_mod_sel = '0; i_cfg_data = '0;
    cyc(3);
    chk("lit_rst_ant", o_ant_pos, 32'h76543210);
    chk("lit_rst_mod", o_mod_sel, 2'd3);
    chk("lit_rst_busy", o_cfg_busy, 1'b0);
    rst_n = 1'b1;
    cyc(5);
    pulse_fram();
    chk("lit_fram_out", o_fram, 1'b1);
    chk("lit_fram_ant", o_ant_pos, 32'h76543210);
    chk("lit_fram_sf", o_sf_cnt, 4'd0);
    cyc(16);
    chk("lit_sf1", o_sf_cnt, 4'd1);
    chk("lit_fram_low", o_fram, 1'b0);
    cyc(16 * 8);
    chk("lit_sf9", o_sf_cnt, 4'd9);
    cyc(16);
    chk("lit_sf_wrap", o_sf_cnt, 4'd0);
    // two-pattern table, 5 MHz mode
    wr(2'd0, 32'h01234567);
    wr(2'd1, 32'h10325476);
    commit(2'd1, 2'd0);
    chk("lit_busy_set", o_cfg_busy, 1'b1);
    cyc(3);
    pulse_fram();
    chk("lit_busy_clr", o_cfg_busy, 1'b0);
    chk("lit_pat0", o_ant_pos, 32'h01234567);
    chk("lit_mod0", o_mod_sel, 2'd0);
    cyc(16);
    chk("lit_pat1", o_ant_pos, 32'h10325476);
    chk("lit_idx1", o_pat_idx, 2'd1);
    cyc(16);
    chk("lit_pat0_again", o_ant_pos, 32'h01234567);
    // rejected writes leave the shadow untouched
    wr(2'd0, 32'h00234567);
    chk("lit_err_dup", o_cfg_err, 1'b1);
    i_err_clr = 1'b1; cyc(1); i_err_clr = 1'b0;
    chk("lit_err_clr", o_cfg_err, 1'b0);
    wr(2'd1, 32'h81234567);
    chk("lit_err_bit3", o_cfg_err, 1'b1);
    i_err_clr = 1'b1; i_cfg_wr = 1'b1; i_cfg_sel = 2'd2; i_cfg_data = 32'h01234566;
    cyc(1);
    i_err_clr = 1'b0; i_cfg_wr = 1'b0;
    chk("lit_err_wins", o_cfg_err, 1'b1);
    i_err_clr = 1'b1; cyc(1); i_err_clr = 1'b0;
    commit(2'd1, 2'd0);
    cyc(2);
    pulse_fram();
    chk("lit_slot0_kept", o_ant_pos, 32'h01234567);
    cyc(16);
    chk("lit_slot1_kept", o_ant_pos, 32'h10325476);
    // enable low forces identity, counters keep running
    i_enable = 1'b0;
    cyc(1);
    chk("lit_dis_ant", o_ant_pos, 32'h76543210);
    chk("lit_dis_idx", o_pat_idx, 2'd0);
    cyc(20);
    i_enable = 1'b1;
    cyc(3);
    // commit coincident with a frame head takes effect one frame later
    wr(2'd0, 32'h23016745);
    i_fram = 1'b1;
    commit(2'd0, 2'd2);
    i_fram = 1'b0;
    chk("lit_coinc_ant", o_ant_pos, 32'h01234567);
    chk("lit_coinc_mod", o_mod_sel, 2'd0);
    chk("lit_coinc_busy", o_cfg_busy, 1'b1);
    cyc(3);
    commit(2'd3, 2'd1);
    chk("lit_busy_commit_err", o_cfg_err, 1'b1);
    i_err_clr = 1'b1; cyc(1); i_err_clr = 1'b0;
    cyc(5);
    i_cfg_wr = 1'b1; i_cfg_sel = 2'd0; i_cfg_data = 32'h45670123;
    pulse_fram();
    i_cfg_wr = 1'b0;
    chk("lit_prewrite_copy", o_ant_pos, 32'h23016745);
    chk("lit_mod2", o_mod_sel, 2'd2);
    cyc(16);
    chk("lit_single_pat", o_ant_pos, 32'h23016745);
    commit(2'd0, 2'd1);
    cyc(4);
    pulse_fram();
    chk("lit_postwrite", o_ant_pos, 32'h45670123);
    chk("lit_mod1", o_mod_sel, 2'd1);
    // head in mid-subframe and head on a subframe wrap
    cyc(23);
    pulse_fram();
    chk("lit_mid_sf", o_sf_cnt, 4'd0);
    cyc(15);
    pulse_fram();
    chk("lit_wrap_sf", o_sf_cnt, 4'd0);
    chk("lit_wrap_fram", o_fram, 1'b1);
    // reset discards a pending commit and the shadow contents
    commit(2'd1, 2'd3);
    chk("lit_busy_pre_rst", o_cfg_busy, 1'b1);
    rst_n = 1'b0;
    cyc(2);
    chk("lit_rst_mid_busy", o_cfg_busy, 1'b0);
    chk("lit_rst_mid_ant", o_ant_pos, 32'h76543210);
    rst_n = 1'b1;
    cyc(3);
    commit(2'd0, 2'd2);
    pulse_fram();
    chk("lit_shadow_lost", o_ant_pos, 32'h76543210);
    chk("lit_shadow_mod", o_mod_sel, 2'd2);
    // silent frame-head source
    cyc(4);
    pulse_fram();
    cyc(159);
    chk("lit_wd_before", o_fram, 1'b0);
    cyc(1);
    chk("lit_wd_fram", o_fram, WD);
    chk("lit_wd_flag", o_wdog, WD);
    chk("lit_wd_sf", o_sf_cnt, 4'd0);
    i_err_clr = 1'b1; cyc(1); i_err_clr = 1'b0;
    chk("lit_wd_clr", o_wdog, 1'b0);
    cyc(10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
